// File: rtl/byte_serial_tx_if.sv
// Word handshake between an upstream byte source and the serial transmitter.
// The master offers a word with in_valid; the slave takes it when in_ready is high.
interface byte_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/byte_serial_tx.sv
// Parallel-to-serial transmitter: start bit (0), WIDTH data bits LSB first,
// stop bit (1), each bit held for BIT_CYCLES clocks. Every output is a flop
// or a decode of the state register, so the line never glitches.
module byte_serial_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    byte_serial_tx_if.slave        bus,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic             tx_q;
    logic             in_ready_q;
    logic             tx_done_q;
    logic             bit_end;
    logic             accept;

    // With one clock per bit the counter never advances and every edge ends a bit.
    assign bit_end = (BIT_CYCLES == 1) || (cnt_q == CNT_LAST);
    assign shift_d = shift_q >> 1;
    assign accept  = bus.in_valid && in_ready_q;

    // Frame sequencer: state, bit timing, shift register and all registered outputs.
    // NOTE: non-blocking assignments make every register below see the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        shift_q    <= bus.in_data;
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_d;
                            idx_q   <= idx_q + IW'(1);
                            tx_q    <= shift_d[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        in_ready_q <= 1'b1;
                        tx_done_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign tx_done      = tx_done_q;
    assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Bench for byte_serial_tx: one instance at BIT_CYCLES=4, one at BIT_CYCLES=1.
// A frame-offset model predicts every output each cycle; directed frames are
// also pinned against hand-written bit sequences.
module tb_byte_serial_tx;

    localparam int W = 8;

    logic clk;
    logic clr_n;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    byte_serial_tx_if #(.WIDTH(W)) bus_a ();
    byte_serial_tx_if #(.WIDTH(W)) bus_b ();

    byte_serial_tx #(.WIDTH(W), .BIT_CYCLES(4)) dut_a (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus     (bus_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .tx_done (done_a)
    );

    byte_serial_tx #(.WIDTH(W), .BIT_CYCLES(1)) dut_b (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus     (bus_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .tx_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described only by the edge offset t since its accept edge:
    // start bit for t in [0,B), data bit i for t in [(1+i)B,(2+i)B), stop
    // bit up to (W+2)B, at which point the transmitter is idle again.
    int         bcyc   [2] = '{4, 1};
    bit         m_act  [2];
    bit         m_rdy  [2];
    bit         m_done [2];
    int         m_t    [2];
    logic [7:0] m_word [2];

    task automatic model_step(input int i, input logic valid, input logic [7:0] data);
        m_done[i] = 1'b0;
        if (!clr_n) begin
            m_act[i] = 1'b0;
            m_rdy[i] = 1'b0;
            m_t[i]   = 0;
        end else if (m_act[i]) begin
            m_t[i]++;
            if (m_t[i] == (W + 2) * bcyc[i]) begin
                m_act[i]  = 1'b0;
                m_rdy[i]  = 1'b1;
                m_done[i] = 1'b1;
            end
        end else if (m_rdy[i] && valid) begin
            m_act[i]  = 1'b1;
            m_rdy[i]  = 1'b0;
            m_t[i]    = 0;
            m_word[i] = data;
        end else begin
            m_rdy[i] = 1'b1;
        end
    endtask

    function automatic logic exp_tx(input int i);
        int b = bcyc[i];
        int t = m_t[i];
        if (!m_act[i])           return 1'b1;
        if (t < b)               return 1'b0;
        if (t < (W + 1) * b)     return m_word[i][t / b - 1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        model_step(0, bus_a.in_valid, bus_a.in_data);
        model_step(1, bus_b.in_valid, bus_b.in_data);
    end

    // Compare every output of both instances against the model, away from the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("A.tx",       tx_a,           exp_tx(0));
            check("A.busy",     busy_a,         m_act[0]);
            check("A.in_ready", bus_a.in_ready, m_rdy[0]);
            check("A.tx_done",  done_a,         m_done[0]);
            check("B.tx",       tx_b,           exp_tx(1));
            check("B.busy",     busy_b,         m_act[1]);
            check("B.in_ready", bus_b.in_ready, m_rdy[1]);
            check("B.tx_done",  done_b,         m_done[1]);
        end
    end

    // ---------------- directed helpers ----------------
    logic tr_tx   [0:127];
    logic tr_rdy  [0:127];
    logic tr_done [0:127];
    logic tr_busy [0:127];

    task automatic wait_ready_a();
        int n = 0;
        while (bus_a.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("A.ready_timeout", 32'd0, 32'd1);
    endtask

    // Offer d0, record n cycles after the accept edge; after the first recorded
    // cycle in_data becomes d1 and in_valid stays at keep.
    task automatic run_a(input logic [7:0] d0, input logic [7:0] d1, input bit keep, input int n);
        wait_ready_a();
        bus_a.in_data  = d0;
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tr_tx[c]   = tx_a;
            tr_rdy[c]  = bus_a.in_ready;
            tr_done[c] = done_a;
            tr_busy[c] = busy_a;
            if (c == 0) begin
                bus_a.in_data  = d1;
                bus_a.in_valid = keep;
            end
        end
        bus_a.in_valid = 1'b0;
    endtask

    // seq[9] is the start bit, seq[0] the stop bit.
    task automatic check_frame(input int off, input logic [9:0] seq, input string tag);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) begin
                check({tag, ".tx"},    tr_tx[off + 4 * b + j],   seq[9 - b]);
                check({tag, ".ready"}, tr_rdy[off + 4 * b + j],  1'b0);
                check({tag, ".done"},  tr_done[off + 4 * b + j], 1'b0);
            end
        end
        check({tag, ".done_end"},  tr_done[off + 40], 1'b1);
        check({tag, ".ready_end"}, tr_rdy[off + 40],  1'b1);
        check({tag, ".busy_end"},  tr_busy[off + 40], 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_done;
        clr_n          = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        @(posedge clk);
        cmp_en = 1'b1;

        // Reset held for three edges, then released.
        for (int r = 0; r < 3; r++) begin
            if (r > 0) @(posedge clk);
            @(negedge clk);
            check("rst.tx",    tx_a,           1'b1);
            check("rst.ready", bus_a.in_ready, 1'b0);
            check("rst.busy",  busy_a,         1'b0);
        end
        clr_n = 1'b1;
        @(negedge clk);
        check("rel.ready", bus_a.in_ready, 1'b1);
        check("rel.tx",    tx_a,           1'b1);
        repeat (4) begin
            @(negedge clk);
            check("idle.tx", tx_a, 1'b1);
        end

        // Single frame 0xA5.
        run_a(8'hA5, 8'hA5, 1'b0, 41);
        check_frame(0, 10'b0101001011, "A5");

        // Back-to-back 0x00 then 0xFF with in_valid held high.
        run_a(8'h00, 8'hFF, 1'b1, 82);
        check_frame(0, 10'b0000000001, "b2b0");
        check("b2b.stop_busy", tr_busy[39], 1'b1);
        check("b2b.gap_busy",  tr_busy[40], 1'b0);
        check("b2b.gap_tx",    tr_tx[40],   1'b1);
        check("b2b.acc_busy",  tr_busy[41], 1'b1);
        check("b2b.acc_tx",    tr_tx[41],   1'b0);
        check_frame(41, 10'b0111111111, "b2b1");

        // Data stability: in_data changes right after the accept.
        run_a(8'h3C, 8'hC3, 1'b0, 41);
        check_frame(0, 10'b0001111001, "stab");

        // Reset during data bit 3 of 0x5A (edge k+18).
        run_a(8'h5A, 8'h5A, 1'b0, 18);
        clr_n = 1'b0;
        @(negedge clk);
        check("mid.tx",    tx_a,           1'b1);
        check("mid.busy",  busy_a,         1'b0);
        check("mid.done",  done_a,         1'b0);
        check("mid.ready", bus_a.in_ready, 1'b0);
        clr_n  = 1'b1;
        n_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_a === 1'b1) n_done++;
        end
        check("mid.no_done", n_done, 0);
        run_a(8'h81, 8'h81, 1'b0, 41);
        check_frame(0, 10'b0100000011, "post_rst");

        // One clock per bit: 0x01.
        begin
            int n = 0;
            logic [9:0] seq1 = 10'b0100000001;
            while (bus_b.in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("B.ready_timeout", 32'd0, 32'd1);
            bus_b.in_data  = 8'h01;
            bus_b.in_valid = 1'b1;
            @(posedge clk);
            for (int c = 0; c <= 10; c++) begin
                @(negedge clk);
                bus_b.in_valid = 1'b0;
                if (c < 10) begin
                    check("B1.tx",   tx_b,   seq1[9 - c]);
                    check("B1.done", done_b, 1'b0);
                end else begin
                    check("B1.done_end",  done_b,         1'b1);
                    check("B1.ready_end", bus_b.in_ready, 1'b1);
                end
            end
        end

        // Random traffic with occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus_a.in_valid = 1'($urandom_range(0, 1));
            bus_a.in_data  = 8'($urandom);
            bus_b.in_valid = 1'($urandom_range(0, 1));
            bus_b.in_data  = 8'($urandom);
            clr_n          = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        clr_n          = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
